// File: rtl/coproc_pkg.sv
// Shared types and constants for the coprocessor result packer.
//   state_e          : packer FSM states
//   ASCII_* constants: character codes emitted on the byte stream
//   DROP_MAX         : saturation value of the drop counter
//   nibble_to_ascii  : 4-bit value -> uppercase ASCII hex character
package coproc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TERM = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] DROP_MAX = 8'hFF;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ASCII_0 + 8'(nib);
    end
    return ASCII_A + 8'(nib - 4'd10);
  endfunction

endpackage : coproc_pkg

// File: rtl/coproc_hex_ascii_enc.sv
// Combinational nibble to uppercase ASCII hex encoder.
//   nibble  : 4-bit value 0..15
//   ascii_c : '0'..'9' / 'A'..'F'
module coproc_hex_ascii_enc
  import coproc_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii_c
);

  assign ascii_c = nibble_to_ascii(nibble);

endmodule : coproc_hex_ascii_enc

// File: rtl/coproc_result_uart_packer.sv
// Captures one result word on din_valid and streams it MSB first to a UART
// TX byte port, as raw bytes or uppercase ASCII hex, optionally terminated
// by a line feed.
//   clk, rst          : clock, asynchronous active-low reset
//   din, din_valid    : result word and its single-cycle strobe
//   busy              : frame in progress (registered)
//   tx_data, tx_valid : byte stream towards the UART (registered)
//   tx_ready          : UART accepts the current byte
//   drop_count        : saturating count of words ignored while busy
module coproc_result_uart_packer
  import coproc_pkg::*;
#(
  parameter int unsigned WIDTH_DIN      = 128,
  parameter bit          ASCII_HEX      = 1'b1,
  parameter bit          APPEND_NEWLINE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_DIN-1:0] din,
  input  logic                 din_valid,
  output logic                 busy,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [7:0]           drop_count
);

  localparam int unsigned SYM_BITS = ASCII_HEX ? 4 : 8;
  localparam int unsigned NUM_SYM  = WIDTH_DIN / SYM_BITS;
  localparam int unsigned CNT_W    = $clog2(WIDTH_DIN / 4 + 1);

  state_e               state_q, state_d;
  logic [WIDTH_DIN-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           drop_q, drop_d;
  logic                 busy_q, busy_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [7:0]           hex_c;
  logic                 hs_c;

  assign hs_c = tx_valid_q & tx_ready;

  // Encoder looks at the next-cycle top nibble so tx_data can be registered.
  coproc_hex_ascii_enc u_enc (
    .nibble  (shift_d[WIDTH_DIN-1 -: 4]),
    .ascii_c (hex_c)
  );

  // Next-state, shift register, symbol counter and drop counter.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;

    unique case (state_q)
      IDLE: begin
        if (din_valid) begin
          shift_d = din;
          cnt_d   = CNT_W'(NUM_SYM);
          state_d = DATA;
        end
      end
      DATA: begin
        if (hs_c) begin
          shift_d = shift_q << SYM_BITS;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = APPEND_NEWLINE ? TERM : IDLE;
          end
        end
      end
      TERM: begin
        if (hs_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Words arriving while a frame is in flight (including its last cycle) are lost.
    if (busy_q && din_valid && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Registered output decode from the next state.
  always_comb begin
    busy_d     = (state_d != IDLE);
    tx_valid_d = (state_d != IDLE);
    tx_data_d  = 8'h00;
    if (state_d == DATA) begin
      tx_data_d = ASCII_HEX ? hex_c : shift_d[WIDTH_DIN-1 -: 8];
    end else if (state_d == TERM) begin
      tx_data_d = ASCII_LF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      drop_q     <= 8'h00;
      busy_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      busy_q     <= busy_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign busy       = busy_q;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign drop_count = drop_q;

endmodule : coproc_result_uart_packer

// File: doc/coproc_result_uart_packer.md
Name: coproc_result_uart_packer

Overview:
Transmit-side counterpart to the coprocessor's word input. It captures one WIDTH_DIN-bit result word on a single-cycle valid pulse and serialises it, MSB first, into a byte stream for the UART TX byte interface. The stream is either raw bytes or uppercase ASCII hex, optionally followed by a line feed. It sits between the coprocessor's dout/dout_valid and the UART transmitter's valid/ready byte port.

Parameters:
WIDTH_DIN, 128, width of the result word; must be a multiple of 8.
ASCII_HEX, 1, 1 = emit WIDTH_DIN/4 uppercase hex characters; 0 = emit WIDTH_DIN/8 raw bytes.
APPEND_NEWLINE, 1, 1 = emit 0x0A after the last data byte (in both modes); 0 = no terminator.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
din  input  WIDTH_DIN  result word (coprocessor dout)
din_valid  input  1  single-cycle pulse; din is sampled on this cycle
busy  output  1  high while a frame is being emitted
tx_data  output  8  byte to the UART TX
tx_valid  output  1  tx_data is valid
tx_ready  input  1  UART TX accepts the byte this cycle
drop_count  output  8  saturating count of din_valid pulses ignored while busy

Behaviour:
- Reset (rst low, asynchronous): state IDLE; busy=0, tx_valid=0, tx_data=0x00, drop_count=0, shift register cleared. Outputs fall low immediately, including mid-frame; no partial frame resumes after reset.
- States: IDLE, DATA, TERM.
- IDLE: busy=0, tx_valid=0. When din_valid=1:
  - load din into the shift register;
  - set the remaining-symbol counter to WIDTH_DIN/4 (hex) or WIDTH_DIN/8 (raw);
  - go to DATA.
- Latency: din_valid at cycle N gives tx_valid=1 with the first symbol at cycle N+1.
- DATA: tx_valid=1. tx_data is the current symbol from the top nibble or byte of the shift register:
  - hex mapping: nibble 0–9 → 0x30+n; nibble 10–15 → 0x41+(n−10); uppercase only.
  - On a handshake (tx_valid & tx_ready): shift left by 4 (hex) or 8 (raw) and decrement the counter.
  - On the handshake of the last symbol: go to TERM if APPEND_NEWLINE=1, otherwise go to IDLE.
- TERM: tx_valid=1, tx_data=0x0A; on handshake go to IDLE.
- Backpressure: while tx_valid=1 and tx_ready=0, tx_data and the state are held stable. tx_valid never drops without a handshake, except on reset.
- tx_ready while tx_valid=0 is ignored.
- busy = (state != IDLE), a registered decode.
- din_valid while busy=1:
  - the word is discarded and the active frame continues unchanged;
  - drop_count increments, saturating at 255.
  - This includes din_valid in the same cycle as the final handshake, because busy is still 1 that cycle.
- din_valid in IDLE in the cycle after a frame completes is accepted normally, giving back-to-back frames with a one-cycle tx_valid gap.
- Frame length: hex = WIDTH_DIN/4 + APPEND_NEWLINE bytes; raw = WIDTH_DIN/8 + APPEND_NEWLINE bytes.
- Counter width: $clog2(WIDTH_DIN/4 + 1) bits.
- All registers are on clk. No clock division or pulse extension: din_valid is a clean single-cycle pulse in the clk domain.

Decomposition:
- Shared package (coproc_pkg):
  - state enum: IDLE, DATA, TERM;
  - constants: ASCII_0=8'h30, ASCII_A=8'h41, ASCII_LF=8'h0A, DROP_MAX=8'hFF;
  - function nibble_to_ascii.
- Sub-module: coproc_hex_ascii_enc, a 4-bit to 8-bit combinational encoder. Instantiate it once on the top nibble.
- The FSM, shift register, symbol counter and drop counter stay in the top module.

Test Plan:
1. WIDTH_DIN=16, ASCII_HEX=1, NL=1, tx_ready=1; din=0x00A5 pulse at cycle 0 -> bytes 0x30,0x30,0x41,0x35,0x0A on cycles 1–5; busy=1 over cycles 1–5, 0 at cycle 6.
2. Hex boundary: din=0x9F0A -> 0x39,0x46,0x30,0x41,0x0A. Then din=0xFFFF -> 0x46×4,0x0A.
3. ASCII_HEX=0, NL=0; din=0x1234 -> 0x12,0x34, then IDLE. Cover WIDTH_DIN=128 with din=0x0102…10 -> 16 bytes 0x01..0x10 in order.
4. Backpressure: hold tx_ready=0 for 3 cycles on the second symbol of test 1 -> tx_data stays 0x30 with tx_valid=1 for all 3 cycles; the sequence is otherwise unchanged.
5. Drops: two din_valid pulses mid-frame plus one on the final handshake cycle -> drop_count=3 and the frame bytes are unchanged. Then 260 drops -> drop_count saturates at 255.
6. Reset: assert rst low mid-frame at a cycle with no clock edge -> tx_valid, busy and drop_count go to 0 immediately. After release, din=0x0001 -> 0x30,0x30,0x30,0x31,0x0A with no leftover bytes from the old frame.
